// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall sequencer for the 5-stage pipeline: decodes per-stage hold/NOP
// controls from load-use, branch, memory-wait and halt conditions.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 4,
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic                  id_uses_a,
    input  logic                  id_uses_b,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken_ex,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_bubble,
    output logic                  exmem_write,
    output logic                  memwb_bubble,
    output logic                  halted,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_n;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_n;
    logic                 err_set;
    logic                 mem_wait;
    logic                 load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_a && (id_rs_a == ex_rd)) ||
                       (id_uses_b && (id_rs_b == ex_rd)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            drain_cnt <= drain_cnt_n;
            if (err_set)
                mem_error <= 1'b1;
            if (!pc_write)
                stall_cycles <= sat_inc(stall_cycles);
        end
    end

    always_comb begin
        state_n      = state;
        wait_cnt_n   = wait_cnt;
        drain_cnt_n  = drain_cnt;
        err_set      = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        halted       = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    state_n      = ST_MEM_WAIT;
                    wait_cnt_n   = WAIT_W'(1);
                end else begin
                    // A taken branch squashes the younger instruction, so its load-use is moot
                    if (branch_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                    if (halt_req) begin
                        state_n     = ST_DRAIN;
                        drain_cnt_n = '0;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_n    = ST_RUN;
                    wait_cnt_n = '0;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    // The RUN entry cycle already counted as wait cycle 1
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                        err_set    = 1'b1;
                        state_n    = ST_RUN;
                        wait_cnt_n = '0;
                    end else begin
                        wait_cnt_n = wait_cnt + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                if (mem_wait) begin
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                end else begin
                    idex_bubble = 1'b1;
                    if (drain_cnt >= DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_n     = ST_HALTED;
                        drain_cnt_n = '0;
                    end else begin
                        drain_cnt_n = drain_cnt + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                halted      = 1'b1;
                if (resume)
                    state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase

        // Pipeline registers see NOPs and holds for as long as reset is asserted
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            halted       = 1'b0;
        end
    end

endmodule
